// File: rtl/bsg_zynq_uart_regs_pkg.sv
// Shared constants for the UART-Lite-compatible AXI-Lite register window:
// register offsets (addr[3:2]), STAT/CTRL bit positions, resp codes, FSM states.
package bsg_zynq_uart_regs_pkg;

  localparam logic [1:0] rx_offset   = 2'd0;
  localparam logic [1:0] tx_offset   = 2'd1;
  localparam logic [1:0] stat_offset = 2'd2;
  localparam logic [1:0] ctrl_offset = 2'd3;

  localparam int stat_rx_valid_bit = 0;
  localparam int stat_rx_full_bit  = 1;
  localparam int stat_tx_empty_bit = 2;
  localparam int stat_tx_full_bit  = 3;
  localparam int stat_intr_en_bit  = 4;
  localparam int stat_overrun_bit  = 5;

  localparam int ctrl_tx_flush_bit = 0;
  localparam int ctrl_rx_flush_bit = 1;
  localparam int ctrl_intr_en_bit  = 4;

  localparam logic [1:0] resp_okay   = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

endpackage

// File: rtl/bsg_zynq_uart_fifo.sv
// 1r1w byte FIFO with flush and a registered head; extra pointer MSB
// distinguishes full from empty so pointers wrap without losing a slot.
module bsg_zynq_uart_fifo #(
  parameter int els_p   = 16,
  parameter int width_p = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [width_p-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic               full,
  output logic               valid,
  output logic               valid_next,
  output logic [width_p-1:0] head
);

  localparam int aw = $clog2(els_p);

  logic [aw:0]        wptr, rptr, wptr_n, rptr_n;
  logic [width_p-1:0] mem [els_p];
  logic [width_p-1:0] head_r, head_n;
  logic               push_ok, pop_ok;

  assign valid   = (wptr != rptr);
  assign full    = (wptr[aw] != rptr[aw]) && (wptr[aw-1:0] == rptr[aw-1:0]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && valid && !flush;
  assign head    = head_r;

  always_comb begin
    wptr_n = wptr;
    rptr_n = rptr;
    if (flush) begin
      rptr_n = wptr;
    end else begin
      if (push_ok) wptr_n = wptr + 1'b1;
      if (pop_ok)  rptr_n = rptr + 1'b1;
    end
    valid_next = (wptr_n != rptr_n);
    head_n     = '0;
    // The slot being written this cycle is the new head only when it lands at rptr_n.
    if (valid_next) begin
      if (push_ok && (wptr[aw-1:0] == rptr_n[aw-1:0])) head_n = push_data;
      else                                             head_n = mem[rptr_n[aw-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      head_r <= '0;
    end else begin
      wptr   <= wptr_n;
      rptr   <= rptr_n;
      head_r <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[aw-1:0]] <= push_data;
  end

endmodule

// File: rtl/bsg_zynq_axil_uart_regs.sv
// AXI4-Lite register window emulating UART-Lite (RX/TX/STAT/CTRL) between
// the zynq UART bridge and the UART PHY byte streams.
module bsg_zynq_axil_uart_regs
  import bsg_zynq_uart_regs_pkg::*;
#(
  parameter int axil_data_width_p = 32,
  parameter int axil_addr_width_p = 10,
  parameter int fifo_els_p        = 16
) (
  input  logic                         clk_i,
  input  logic                         aresetn_i,
  input  logic [axil_addr_width_p-1:0] s_axil_awaddr_i,
  input  logic [2:0]                   s_axil_awprot_i,
  input  logic                         s_axil_awvalid_i,
  output logic                         s_axil_awready_o,
  input  logic [axil_data_width_p-1:0] s_axil_wdata_i,
  input  logic [3:0]                   s_axil_wstrb_i,
  input  logic                         s_axil_wvalid_i,
  output logic                         s_axil_wready_o,
  output logic [1:0]                   s_axil_bresp_o,
  output logic                         s_axil_bvalid_o,
  input  logic                         s_axil_bready_i,
  input  logic [axil_addr_width_p-1:0] s_axil_araddr_i,
  input  logic [2:0]                   s_axil_arprot_i,
  input  logic                         s_axil_arvalid_i,
  output logic                         s_axil_arready_o,
  output logic [axil_data_width_p-1:0] s_axil_rdata_o,
  output logic [1:0]                   s_axil_rresp_o,
  output logic                         s_axil_rvalid_o,
  input  logic                         s_axil_rready_i,
  input  logic                         rx_v_i,
  input  logic [7:0]                   rx_data_i,
  output logic                         tx_v_o,
  output logic [7:0]                   tx_data_o,
  input  logic                         tx_yumi_i,
  output logic                         intr_o
);

  w_state_e w_state, w_state_n;
  r_state_e r_state, r_state_n;

  logic                         rst_done;
  logic                         tx_push, tx_flush, rx_flush, rx_pop, stat_rd, intr_en_ld;
  logic [1:0]                   bresp_r, bresp_n;
  logic [axil_data_width_p-1:0] rdata_r, rdata_n;
  logic                         intr_en, overrun, intr_r;
  logic                         rx_full, rx_valid, rx_valid_next;
  logic                         tx_full, tx_valid, tx_valid_next;
  logic [7:0]                   rx_head, tx_head;
  logic                         unused_inputs;

  assign unused_inputs = ^{s_axil_awaddr_i, s_axil_araddr_i, s_axil_awprot_i,
                           s_axil_arprot_i, s_axil_wstrb_i, s_axil_wdata_i};

  // Readies stay low until the first clock after reset release.
  assign s_axil_awready_o = rst_done && (w_state == W_IDLE) && s_axil_awvalid_i && s_axil_wvalid_i;
  assign s_axil_wready_o  = s_axil_awready_o;
  assign s_axil_arready_o = rst_done && (r_state == R_IDLE);
  assign s_axil_bvalid_o  = (w_state == W_RESP);
  assign s_axil_rvalid_o  = (r_state == R_RESP);
  assign s_axil_bresp_o   = bresp_r;
  assign s_axil_rresp_o   = resp_okay;
  assign s_axil_rdata_o   = rdata_r;
  assign tx_v_o           = tx_valid;
  assign tx_data_o        = tx_head;
  assign intr_o           = intr_r;

  always_comb begin
    w_state_n  = w_state;
    bresp_n    = bresp_r;
    tx_push    = 1'b0;
    tx_flush   = 1'b0;
    rx_flush   = 1'b0;
    intr_en_ld = 1'b0;
    case (w_state)
      W_IDLE: if (s_axil_awready_o) begin
        w_state_n = W_RESP;
        bresp_n   = resp_okay;
        case (s_axil_awaddr_i[3:2])
          tx_offset: begin
            tx_push = 1'b1;
            if (tx_full) bresp_n = resp_slverr;
          end
          ctrl_offset: begin
            tx_flush   = s_axil_wdata_i[ctrl_tx_flush_bit];
            rx_flush   = s_axil_wdata_i[ctrl_rx_flush_bit];
            intr_en_ld = 1'b1;
          end
          default: ;
        endcase
      end
      W_RESP: if (s_axil_bready_i) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_n = r_state;
    rdata_n   = rdata_r;
    rx_pop    = 1'b0;
    stat_rd   = 1'b0;
    case (r_state)
      R_IDLE: if (s_axil_arready_o && s_axil_arvalid_i) begin
        r_state_n = R_RESP;
        rdata_n   = '0;
        case (s_axil_araddr_i[3:2])
          rx_offset: if (rx_valid) begin
            rdata_n[7:0] = rx_head;
            rx_pop       = 1'b1;
          end
          stat_offset: begin
            rdata_n[stat_rx_valid_bit] = rx_valid;
            rdata_n[stat_rx_full_bit]  = rx_full;
            rdata_n[stat_tx_empty_bit] = !tx_valid;
            rdata_n[stat_tx_full_bit]  = tx_full;
            rdata_n[stat_intr_en_bit]  = intr_en;
            rdata_n[stat_overrun_bit]  = overrun;
            stat_rd                    = 1'b1;
          end
          default: ;
        endcase
      end
      R_RESP: if (s_axil_rready_i) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_state_n;
      r_state <= r_state_n;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rst_done <= 1'b0;
      bresp_r  <= resp_okay;
      rdata_r  <= '0;
      intr_en  <= 1'b0;
      overrun  <= 1'b0;
      intr_r   <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      bresp_r  <= bresp_n;
      rdata_r  <= rdata_n;
      if (intr_en_ld) intr_en <= s_axil_wdata_i[ctrl_intr_en_bit];
      // A same-cycle overrun wins over the STAT read clear.
      overrun  <= (rx_v_i && rx_full) || (overrun && !stat_rd);
      intr_r   <= intr_en && ((!rx_valid && rx_valid_next) || (tx_valid && !tx_valid_next));
    end
  end

  bsg_zynq_uart_fifo #(.els_p(fifo_els_p), .width_p(8)) rx_fifo (
    .clk(clk_i), .rst_n(aresetn_i),
    .push(rx_v_i), .push_data(rx_data_i), .pop(rx_pop), .flush(rx_flush),
    .full(rx_full), .valid(rx_valid), .valid_next(rx_valid_next), .head(rx_head)
  );

  bsg_zynq_uart_fifo #(.els_p(fifo_els_p), .width_p(8)) tx_fifo (
    .clk(clk_i), .rst_n(aresetn_i),
    .push(tx_push), .push_data(s_axil_wdata_i[7:0]), .pop(tx_yumi_i), .flush(tx_flush),
    .full(tx_full), .valid(tx_valid), .valid_next(tx_valid_next), .head(tx_head)
  );

endmodule

// File: tb/tb_bsg_zynq_axil_uart_regs.sv
// Bench for the UART-Lite register window: directed scenarios with literal
// expectations, then random traffic checked against a queue-based model.
module tb_bsg_zynq_axil_uart_regs;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [9:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
  logic        rx_v = 0, tx_yumi = 0;
  logic [7:0]  rx_data = '0;

  logic        awready, wready, bvalid, arready, rvalid, tx_v, intr;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  tx_data;

  int errors = 0;
  int checks = 0;
  int intr_cnt = 0;

  always #5 clk = ~clk;

  bsg_zynq_axil_uart_regs dut (
    .clk_i(clk), .aresetn_i(aresetn),
    .s_axil_awaddr_i(awaddr), .s_axil_awprot_i(awprot), .s_axil_awvalid_i(awvalid),
    .s_axil_awready_o(awready),
    .s_axil_wdata_i(wdata), .s_axil_wstrb_i(wstrb), .s_axil_wvalid_i(wvalid),
    .s_axil_wready_o(wready),
    .s_axil_bresp_o(bresp), .s_axil_bvalid_o(bvalid), .s_axil_bready_i(bready),
    .s_axil_araddr_i(araddr), .s_axil_arprot_i(arprot), .s_axil_arvalid_i(arvalid),
    .s_axil_arready_o(arready),
    .s_axil_rdata_o(rdata), .s_axil_rresp_o(rresp), .s_axil_rvalid_o(rvalid),
    .s_axil_rready_i(rready),
    .rx_v_i(rx_v), .rx_data_i(rx_data), .tx_v_o(tx_v), .tx_data_o(tx_data),
    .tx_yumi_i(tx_yumi), .intr_o(intr)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Behavioural model: byte queues plus busy flags per channel.
  logic [7:0]  m_rxq[$];
  logic [7:0]  m_txq[$];
  bit          m_intr_en = 0, m_overrun = 0, m_wbusy = 0, m_rbusy = 0, m_rdy = 0, m_intr = 0;
  logic [1:0]  m_bresp = '0;
  logic [31:0] m_rdata = '0;

  always @(posedge clk or negedge aresetn) begin : model
    bit rx_e, rx_f, tx_e, tx_f, pop_rx, clr, fl_tx, fl_rx, push_tx, en_pre;
    logic [7:0] tx_b;
    if (!aresetn) begin
      m_rxq.delete(); m_txq.delete();
      m_intr_en = 0; m_overrun = 0; m_wbusy = 0; m_rbusy = 0; m_rdy = 0; m_intr = 0;
      m_bresp = '0; m_rdata = '0;
    end else begin
      rx_e = (m_rxq.size() == 0); rx_f = (m_rxq.size() == N);
      tx_e = (m_txq.size() == 0); tx_f = (m_txq.size() == N);
      en_pre = m_intr_en;
      pop_rx = 0; clr = 0; fl_tx = 0; fl_rx = 0; push_tx = 0; tx_b = '0;
      if (m_rbusy) begin
        if (rready) m_rbusy = 0;
      end else if (m_rdy && arvalid) begin
        m_rbusy = 1; m_rdata = '0;
        case (araddr[3:2])
          2'd0: if (!rx_e) begin m_rdata = {24'h0, m_rxq[0]}; pop_rx = 1; end
          2'd2: begin
            m_rdata = 32'({m_overrun, m_intr_en, tx_f, tx_e, rx_f, !rx_e});
            clr = 1;
          end
          default: ;
        endcase
      end
      if (m_wbusy) begin
        if (bready) m_wbusy = 0;
      end else if (m_rdy && awvalid && wvalid) begin
        m_wbusy = 1; m_bresp = 2'b00;
        case (awaddr[3:2])
          2'd1: if (tx_f) m_bresp = 2'b10; else begin push_tx = 1; tx_b = wdata[7:0]; end
          2'd3: begin fl_tx = wdata[0]; fl_rx = wdata[1]; m_intr_en = wdata[4]; end
          default: ;
        endcase
      end
      if (fl_tx) m_txq.delete();
      else begin
        if (tx_yumi && !tx_e) void'(m_txq.pop_front());
        if (push_tx) m_txq.push_back(tx_b);
      end
      if (fl_rx) m_rxq.delete();
      else begin
        if (pop_rx) void'(m_rxq.pop_front());
        if (rx_v && !rx_f) m_rxq.push_back(rx_data);
      end
      if (rx_v && rx_f) m_overrun = 1;
      else if (clr)     m_overrun = 0;
      m_intr = en_pre && ((rx_e && m_rxq.size() != 0) || (!tx_e && m_txq.size() == 0));
      m_rdy = 1;
    end
  end

  always @(negedge clk) begin : compare
    bit aw_exp;
    aw_exp = m_rdy && !m_wbusy && awvalid && wvalid;
    chk("awready", awready, aw_exp);
    chk("wready", wready, aw_exp);
    chk("arready", arready, m_rdy && !m_rbusy);
    chk("bvalid", bvalid, m_wbusy);
    if (m_wbusy) chk("bresp", bresp, m_bresp);
    chk("rvalid", rvalid, m_rbusy);
    if (m_rbusy) chk("rdata", rdata, m_rdata);
    chk("rresp", rresp, 0);
    chk("tx_v", tx_v, m_txq.size() != 0);
    chk("tx_data", tx_data, (m_txq.size() != 0) ? m_txq[0] : 8'h00);
    chk("intr", intr, m_intr);
    if (intr) intr_cnt++;
  end

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    if (!awready) chk("aw_timeout", awready, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bvalid && n < 20);
    if (!bvalid) chk("b_timeout", bvalid, 1);
    resp = bresp;
    @(posedge clk);
  endtask

  task automatic do_read(input logic [9:0] a, output logic [31:0] d);
    int n;
    @(posedge clk); #1;
    araddr = a; arvalid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    if (!arready) chk("ar_timeout", arready, 1);
    @(posedge clk); #1;
    arvalid = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rvalid && n < 20);
    if (!rvalid) chk("r_timeout", rvalid, 1);
    d = rdata;
    @(posedge clk);
  endtask

  task automatic push_rx(input logic [7:0] b);
    @(posedge clk); #1;
    rx_v = 1; rx_data = b;
    @(posedge clk); #1;
    rx_v = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [1:0]  r;
    logic [31:0] d;
    int          c0, n;

    #1;
    chk("rst_awready", awready, 0); chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);   chk("rst_rvalid", rvalid, 0);
    chk("rst_tx_v", tx_v, 0);       chk("rst_tx_data", tx_data, 0);
    chk("rst_intr", intr, 0);       chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    repeat (3) @(posedge clk); #1 aresetn = 1;
    repeat (2) @(posedge clk);

    push_rx(8'h41); push_rx(8'h42);
    do_read(10'h0, d); chk("rx_first", d, 32'h41);
    do_read(10'h0, d); chk("rx_second", d, 32'h42);
    do_read(10'h0, d); chk("rx_empty_read", d, 32'h0);
    do_read(10'h8, d); chk("stat_rx_valid", d[0], 0);

    for (int i = 0; i < 17; i++) begin
      do_write(10'h4, 32'hA0 + i, r);
      chk("tx_fill_bresp", r, (i < 16) ? 2'b00 : 2'b10);
    end
    do_read(10'h8, d); chk("stat_tx_full", d, 32'h08);
    do_write(10'hC, 32'h01, r); chk("ctrl_bresp", r, 2'b00);
    do_read(10'h8, d); chk("stat_tx_flushed", d, 32'h04);

    do_write(10'h4, 32'h77, r);
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1 rx_v = 1; rx_data = 8'(i);
    end
    @(posedge clk); #1 rx_v = 0;
    do_read(10'h8, d); chk("stat_overrun", d, 32'h23);
    do_read(10'h8, d); chk("stat_overrun_clr", d, 32'h03);
    chk("tx_head_77", tx_data, 8'h77);

    do_write(10'hC, 32'h02, r);
    c0 = intr_cnt;
    do_write(10'hC, 32'h10, r);
    push_rx(8'h5A);
    repeat (3) @(posedge clk);
    chk("intr_rx_pulse", intr_cnt - c0, 1);
    @(posedge clk); #1;
    n = 0;
    while (tx_v && n < 40) begin tx_yumi = 1; @(posedge clk); #1; n++; end
    tx_yumi = 0;
    chk("tx_drain", tx_v, 0);
    repeat (3) @(posedge clk);
    chk("intr_tx_pulse", intr_cnt - c0, 2);

    @(posedge clk); #1;
    awaddr = 10'h4; wdata = 32'h55; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_bvalid", bvalid, 1); chk("hold_bresp", bresp, 0); chk("hold_awready", awready, 0);
    end
    @(posedge clk); #1 awvalid = 0; wvalid = 0; bready = 1;
    @(posedge clk); #1;
    araddr = 10'h8; arvalid = 1; rready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 20);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", rvalid, 1); chk("hold_rdata", rdata, 32'h11); chk("hold_arready", arready, 0);
    end
    @(posedge clk); #1 arvalid = 0; rready = 1;
    chk("tx_head_55", tx_data, 8'h55);

    @(posedge clk); #1;
    awaddr = 10'h4; wdata = 32'h66; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!awready && n < 20);
    @(posedge clk); #1 awvalid = 0; wvalid = 0;
    @(negedge clk); chk("pre_rst_bvalid", bvalid, 1);
    #2 aresetn = 0;
    #1;
    chk("midrst_bvalid", bvalid, 0); chk("midrst_arready", arready, 0);
    chk("midrst_tx_v", tx_v, 0);     chk("midrst_intr", intr, 0);
    repeat (2) @(posedge clk); #1 aresetn = 1; bready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_bvalid", bvalid, 0); chk("post_rst_rvalid", rvalid, 0);
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int ph;
      ph = cyc / 500;
      @(posedge clk); #1;
      awvalid = ($urandom_range(0, 2) == 0);
      wvalid  = ($urandom_range(0, 3) != 0);
      awaddr  = 10'($urandom);
      wdata   = $urandom;
      if (awaddr[3:2] == 2'b11 && $urandom_range(0, 5) != 0) wdata[1:0] = 2'b00;
      awprot  = 3'($urandom); arprot = 3'($urandom); wstrb = 4'($urandom);
      bready  = ($urandom_range(0, 3) != 0);
      arvalid = ($urandom_range(0, 1) == 0);
      araddr  = 10'($urandom);
      rready  = ($urandom_range(0, 3) != 0);
      rx_v    = (ph % 2 == 1) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 4) == 0);
      rx_data = 8'($urandom);
      tx_yumi = tx_v && ((ph % 3 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0));
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0; rx_v = 0; tx_yumi = 0; bready = 1; rready = 1;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bsg_zynq_axil_uart_regs.md
# bsg_zynq_axil_uart_regs

AXI4-Lite subordinate that implements the UART-Lite-compatible register window which `bsg_zynq_uart_bridge` polls and writes at `uart_base_addr_p`. It responds to single-beat AXI-Lite reads and writes, buffers received bytes in an RX FIFO and outgoing bytes in a TX FIFO, and exposes byte streams toward the serializer/deserializer. It sits between the bridge's `m_axil_*` port and the UART PHY.

## Interface
- `axil_data_width_p`, 32, AXI-Lite data width; only 32 is supported.
- `axil_addr_width_p`, 10, AXI-Lite address width; only `addr[3:2]` is decoded.
- `fifo_els_p`, 16, depth of each FIFO; must be a power of 2, at least 2.

One clock; reset is asynchronous and active-low.
- `clk_i`, in, 1, clock.
- `aresetn_i`, in, 1, asynchronous active-low reset.
- `s_axil_aw{addr,prot,valid}_i` / `awready_o`: write address channel, with `awaddr` at `axil_addr_width_p` bits and `awprot` at 3 bits (ignored).
- `s_axil_w{data,strb,valid}_i` / `wready_o`: write data channel, with `wdata` at 32 bits and `wstrb` at 4 bits (ignored).
- `s_axil_bresp_o` (2 bits), `s_axil_bvalid_o` (1 bit), `s_axil_bready_i` (1 bit): write response channel.
- `s_axil_ar{addr,prot,valid}_i` / `arready_o`: read address channel.
- `s_axil_rdata_o` (32 bits), `rresp_o` (2 bits), `rvalid_o` (1 bit), `rready_i` (1 bit): read data channel.
- `rx_v_i`, in, 1: received byte strobe; there is no backpressure.
- `rx_data_i`, in, 8: received byte.
- `tx_v_o`, out, 1: byte available for transmission.
- `tx_data_o`, out, 8: head of the TX FIFO.
- `tx_yumi_i`, in, 1: PHY consumes the byte; legal only while `tx_v_o` is high.
- `intr_o`, out, 1: one-cycle interrupt pulse.

## Operation
- **Register map**, decoded on `addr[3:2]`:
  - `0x0 RX` (read-only): `rdata[7:0]` is the RX head and the read pops it. If RX is empty, the read returns 0 with no pop.
  - `0x4 TX` (write-only): a write pushes `wdata[7:0]`. If TX is full, the byte is dropped and `bresp` is 2'b10 (SLVERR). Otherwise `bresp` is 2'b00.
  - `0x8 STAT` (read-only): bit0 `rx_valid`, bit1 `rx_full`, bit2 `tx_empty`, bit3 `tx_full`, bit4 `intr_en`, bit5 `overrun`. Reading STAT clears `overrun`.
  - `0xC CTRL` (write-only): bit0 flushes TX, bit1 flushes RX, bit4 sets `intr_en` (level; the write value is stored).
  - Writes to RX/STAT and reads of TX/CTRL complete with OKAY, have no effect, and reads return 0.
- **Write FSM** (`W_IDLE`, `W_RESP`):
  - `awready_o` = `wready_o` = (state == `W_IDLE`) & `awvalid` & `wvalid`, so address and data are accepted in the same cycle.
  - On acceptance the side effect occurs and the FSM moves to `W_RESP`.
  - `bvalid_o` is held until `bready_i`, then the FSM returns to `W_IDLE`.
- **Read FSM** (`R_IDLE`, `R_RESP`):
  - `arready_o` = (state == `R_IDLE`).
  - On acceptance, `rdata` is registered, any pop occurs, and the FSM moves to `R_RESP`.
  - `rvalid_o` is held with stable `rdata` until `rready_i`.
  - `rresp_o` is always 2'b00.
- **RX path:** `rx_v_i` while RX is not full pushes the byte. `rx_v_i` while RX is full drops the byte and sets the sticky `overrun`.
- **Interrupt:** with `intr_en` set, `intr_o` pulses for one cycle when RX goes empty→nonempty or TX goes nonempty→empty.
- **Simultaneous events:**
  - Fullness and emptiness are evaluated on pre-cycle state. A push to a full FIFO is refused even if a pop happens in the same cycle.
  - A flush beats a same-cycle push or pop.
  - An `overrun` set and a STAT read in the same cycle leave `overrun` = 1.

## Timing
- **Reset values:** all `*ready_o`, `bvalid_o`, `rvalid_o`, `tx_v_o` and `intr_o` are 0; `bresp`, `rresp`, `rdata` and `tx_data_o` are 0; both FIFOs are empty; `intr_en` and `overrun` are 0; both FSMs are IDLE.
- **Reset mid-transaction:** reset aborts immediately and outputs take their reset values asynchronously. No response is generated after deassertion.
- **Write latency:** `bvalid_o` rises on the cycle after aw/w acceptance.
- **Read latency:** `rvalid_o` rises on the cycle after ar acceptance.
- **Throughput:** at most one transaction per channel every 2 cycles.
- **TX visibility:** `tx_v_o`/`tx_data_o` are registered FIFO outputs; a pushed byte is visible the cycle after the write handshake.
- **FIFO pointers:** each FIFO uses `$clog2(fifo_els_p)+1`-bit pointers, and pointers wrap without loss.

## Structure
- Package `bsg_zynq_uart_regs_pkg` holds:
  - the register offsets (`rx_offset`, `tx_offset`, `stat_offset`, `ctrl_offset`),
  - the STAT/CTRL bit indices,
  - the resp encodings,
  - an enum for the FSM states.
- One sub-module, `bsg_zynq_uart_fifo` (1r1w, flush input, registered head), is instantiated twice.

## Test plan
- Drive `rx_v_i` with 0x41 then 0x42; read `0x0` twice → returns 0x41 then 0x42. A third read → 0. STAT bit0 then reads 0.
- Write `0x4` 17 times with `fifo_els_p`=16 and `tx_yumi_i`=0 → first 16 writes get `bresp` 0, the 17th gets 2'b10. STAT reads 0x08.
- Push 17 RX bytes → STAT reads 0x23. A second STAT read → 0x03.
- Write CTRL=0x10, then RX one byte → `intr_o` pulses exactly once. Drain TX to empty → one more pulse.
- Hold `bready_i`/`rready_i` low for 5 cycles → `bvalid`/`rvalid` and `rdata` stay stable, and no second accept occurs.
- Assert `aresetn_i` low during `W_RESP` → `bvalid_o` drops the same cycle. After release, an idle bus produces no response.
